// File: rtl/aes_block_loader.sv
// Byte-serial key/plaintext assembler feeding the AES encrypt core.
// Optional in_last frame checking: define AES_LOADER_FRAME_CHECK_EN.
module aes_block_loader #(
    parameter bit HOLD_KEY = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       in_byte,
    input  logic             in_valid,
    input  logic             in_is_key,
    input  logic             in_last,
    output logic             in_ready,
    output logic [15:0][7:0] state,
    output logic [15:0][7:0] key,
    output logic             blk_valid,
    input  logic             blk_ready,
    output logic             frame_err
);

    typedef enum logic {FILL, HOLD} fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [3:0]       data_cnt_q, data_cnt_d;
    logic [3:0]       key_cnt_q, key_cnt_d;
    logic             data_full_q, data_full_d;
    logic             key_loaded_q, key_loaded_d;
    logic [15:0][7:0] state_q, state_d;
    logic [15:0][7:0] key_q, key_d;
    logic             blk_valid_q, blk_valid_d;
    logic             frame_err_q, frame_err_d;
    logic             accept;

`ifndef AES_LOADER_FRAME_CHECK_EN
    logic unused_in_last;
    assign unused_in_last = in_last;
`endif

    // Once the data half is full, only key bytes may enter.
    assign in_ready  = (fsm_q == FILL) && (!data_full_q || in_is_key);
    assign accept    = in_valid && in_ready;
    assign state     = state_q;
    assign key       = key_q;
    assign blk_valid = blk_valid_q;
    assign frame_err = frame_err_q;

    always_comb begin
        fsm_d        = fsm_q;
        data_cnt_d   = data_cnt_q;
        key_cnt_d    = key_cnt_q;
        data_full_d  = data_full_q;
        key_loaded_d = key_loaded_q;
        state_d      = state_q;
        key_d        = key_q;
        blk_valid_d  = blk_valid_q;
        frame_err_d  = 1'b0;
        unique case (fsm_q)
            FILL: begin
                if (accept && in_is_key) begin
                    key_d[key_cnt_q] = in_byte;
                    key_cnt_d = key_cnt_q + 4'd1;
                    if (key_cnt_q == 4'd0)
                        key_loaded_d = 1'b0;
                    if (key_cnt_q == 4'd15)
                        key_loaded_d = 1'b1;
                end
                if (accept && !in_is_key) begin
`ifdef AES_LOADER_FRAME_CHECK_EN
                    if (in_last != (data_cnt_q == 4'd15)) begin
                        data_cnt_d  = 4'd0;
                        frame_err_d = 1'b1;
                    end else
`endif
                    begin
                        state_d[data_cnt_q] = in_byte;
                        data_cnt_d = data_cnt_q + 4'd1;
                        if (data_cnt_q == 4'd15)
                            data_full_d = 1'b1;
                    end
                end
                // Decide on next-state flags so blk_valid follows the last byte by one cycle.
                if (data_full_d && key_loaded_d) begin
                    fsm_d       = HOLD;
                    blk_valid_d = 1'b1;
                end
            end
            HOLD: begin
                if (blk_ready) begin
                    data_full_d = 1'b0;
                    if (!HOLD_KEY)
                        key_loaded_d = 1'b0;
                    fsm_d       = FILL;
                    blk_valid_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q        <= FILL;
            data_cnt_q   <= 4'd0;
            key_cnt_q    <= 4'd0;
            data_full_q  <= 1'b0;
            key_loaded_q <= 1'b0;
            state_q      <= '0;
            key_q        <= '0;
            blk_valid_q  <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            data_cnt_q   <= data_cnt_d;
            key_cnt_q    <= key_cnt_d;
            data_full_q  <= data_full_d;
            key_loaded_q <= key_loaded_d;
            state_q      <= state_d;
            key_q        <= key_d;
            blk_valid_q  <= blk_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

endmodule

// File: tb/tb_aes_block_loader.sv
// Directed bench for aes_block_loader (HOLD_KEY=1 and HOLD_KEY=0 instances).
module tb_aes_block_loader;

    logic             clk = 1'b0;
    logic             reset;
    logic [7:0]       in_byte;
    logic             in_valid;
    logic             in_is_key;
    logic             in_last;
    logic             blk_ready;
    logic             in_ready, in_ready0;
    logic [15:0][7:0] state, state0;
    logic [15:0][7:0] key, key0;
    logic             blk_valid, blk_valid0;
    logic             frame_err, frame_err0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aes_block_loader #(.HOLD_KEY(1'b1)) u_dut (
        .clk(clk), .reset(reset), .in_byte(in_byte),
        .in_valid(in_valid), .in_is_key(in_is_key),
        .in_last(in_last), .in_ready(in_ready),
        .state(state), .key(key), .blk_valid(blk_valid),
        .blk_ready(blk_ready), .frame_err(frame_err)
    );

    aes_block_loader #(.HOLD_KEY(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .in_byte(in_byte),
        .in_valid(in_valid), .in_is_key(in_is_key),
        .in_last(in_last), .in_ready(in_ready0),
        .state(state0), .key(key0), .blk_valid(blk_valid0),
        .blk_ready(blk_ready), .frame_err(frame_err0)
    );

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic do_reset();
        in_byte = 8'h00; in_valid = 1'b0; in_is_key = 1'b0;
        in_last = 1'b0; blk_ready = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic k, input logic l);
        int n;
        in_byte = b; in_is_key = k; in_last = l; in_valid = 1'b1;
        #1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n == 50) begin
            checks++; errors++;
            $display("FAIL send_timeout in_ready stuck 0 want 1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (state !== 128'h0) begin
            errors++; $display("FAIL rst_state got %h want 0", state);
        end
        checks++;
        if (key !== 128'h0) begin
            errors++; $display("FAIL rst_key got %h want 0", key);
        end
        checks++;
        if (blk_valid !== 1'b0) begin
            errors++; $display("FAIL rst_valid got %b want 0", blk_valid);
        end
        checks++;
        if (frame_err !== 1'b0) begin
            errors++; $display("FAIL rst_ferr got %b want 0", frame_err);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_ready got %b want 1", in_ready);
        end
    endtask

    task automatic test_basic();
        do_reset();
        blk_ready = 1'b1;
        for (int i = 0; i < 16; i++) send(8'(i), 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) send(8'(i * 17), 1'b0, i == 15);
        checks++;
        if (blk_valid !== 1'b1) begin
            errors++; $display("FAIL basic_valid got %b want 1", blk_valid);
        end
        checks++;
        if (key !== 128'h0f0e0d0c0b0a09080706050403020100) begin
            errors++; $display("FAIL basic_key got %h", key);
        end
        checks++;
        if (state !== 128'hffeeddccbbaa99887766554433221100) begin
            errors++; $display("FAIL basic_state got %h", state);
        end
        @(posedge clk); #1;
        checks++;
        if (blk_valid !== 1'b0) begin
            errors++; $display("FAIL basic_pulse got %b want 0", blk_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL basic_refill got %b want 1", in_ready);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0][7:0] es;
        for (int i = 0; i < 16; i++) es[i] = 8'(8'h30 + i);
        do_reset();
        for (int i = 0; i < 16; i++) send(8'(i), 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) send(8'(8'h30 + i), 1'b0, i == 15);
        in_byte = 8'h55; in_is_key = 1'b0; in_last = 1'b0;
        in_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (in_ready !== 1'b0 || blk_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold c%0d rdy %b vld %b want 0 1",
                         c, in_ready, blk_valid);
            end
            checks++;
            if (state !== es || key !== 128'h0f0e0d0c0b0a09080706050403020100) begin
                errors++;
                $display("FAIL bp_stable c%0d state %h key %h", c, state, key);
            end
            @(posedge clk); #1;
        end
        blk_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (blk_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release vld %b rdy %b want 0 1", blk_valid, in_ready);
        end
        in_valid = 1'b0;
        checks++;
        if (state !== es) begin
            errors++; $display("FAIL bp_noaccept got %h want %h", state, es);
        end
    endtask

    task automatic test_key_reuse();
        logic [15:0][7:0] ek, ek2, eb;
        for (int i = 0; i < 16; i++) begin
            ek[i]  = 8'(i);
            ek2[i] = 8'(8'h80 + i);
            eb[i]  = 8'(8'h50 + i);
        end
        do_reset();
        blk_ready = 1'b1;
        for (int i = 0; i < 16; i++) send(8'(i), 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) send(8'(8'h40 + i), 1'b0, i == 15);
        checks++;
        if (blk_valid !== 1'b1 || blk_valid0 !== 1'b1 || key !== ek) begin
            errors++;
            $display("FAIL reuse_a vld %b vld0 %b key %h", blk_valid, blk_valid0, key);
        end
        for (int i = 0; i < 16; i++) send(8'(8'h50 + i), 1'b0, i == 15);
        checks++;
        if (blk_valid !== 1'b1 || key !== ek || state !== eb) begin
            errors++;
            $display("FAIL reuse_b vld %b key %h state %h", blk_valid, key, state);
        end
        checks++;
        if (blk_valid0 !== 1'b0) begin
            errors++; $display("FAIL nohold_b vld0 %b want 0", blk_valid0);
        end
        in_byte = 8'h99; in_is_key = 1'b0; in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready0 !== 1'b0) begin
            errors++; $display("FAIL nohold_stall rdy0 %b want 0", in_ready0);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 15; i++) send(8'(8'h80 + i), 1'b1, 1'b0);
        checks++;
        if (blk_valid0 !== 1'b0) begin
            errors++; $display("FAIL nohold_k15 vld0 %b want 0", blk_valid0);
        end
        send(8'h8f, 1'b1, 1'b0);
        checks++;
        if (blk_valid0 !== 1'b1 || key0 !== ek2 || state0 !== eb) begin
            errors++;
            $display("FAIL nohold_k16 vld0 %b key0 %h state0 %h",
                     blk_valid0, key0, state0);
        end
    endtask

    task automatic test_data_before_key();
        logic [15:0][7:0] ek, es;
        for (int i = 0; i < 16; i++) begin
            ek[i] = 8'(8'hc0 + i);
            es[i] = 8'(8'h60 + i);
        end
        do_reset();
        blk_ready = 1'b1;
        for (int i = 0; i < 16; i++) send(8'(8'h60 + i), 1'b0, i == 15);
        checks++;
        if (blk_valid !== 1'b0) begin
            errors++; $display("FAIL dbk_valid got %b want 0", blk_valid);
        end
        in_byte = 8'h77; in_is_key = 1'b0; in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL dbk_refuse got %b want 0", in_ready);
        end
        in_is_key = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL dbk_keyok got %b want 1", in_ready);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 15; i++) send(8'(8'hc0 + i), 1'b1, 1'b0);
        in_is_key = 1'b0; in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0 || blk_valid !== 1'b0) begin
            errors++;
            $display("FAIL dbk_k15 rdy %b vld %b want 0 0", in_ready, blk_valid);
        end
        in_valid = 1'b0;
        send(8'hcf, 1'b1, 1'b0);
        checks++;
        if (blk_valid !== 1'b1 || key !== ek || state !== es) begin
            errors++;
            $display("FAIL dbk_done vld %b key %h state %h", blk_valid, key, state);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0][7:0] ek, es;
        for (int i = 0; i < 16; i++) begin
            ek[i] = 8'(8'h10 + i);
            es[i] = 8'(8'h20 + i);
        end
        do_reset();
        blk_ready = 1'b1;
        for (int i = 0; i < 7; i++) send(8'(8'he0 + i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send(8'(8'hd0 + i), 1'b1, 1'b0);
        reset = 1'b1;
        #1;
        checks++;
        if (state !== 128'h0 || key !== 128'h0 || blk_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_async state %h key %h vld %b", state, key, blk_valid);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        for (int i = 0; i < 16; i++) send(8'(8'h10 + i), 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) send(8'(8'h20 + i), 1'b0, i == 15);
        checks++;
        if (blk_valid !== 1'b1 || key !== ek || state !== es) begin
            errors++;
            $display("FAIL mid_reload vld %b key %h state %h", blk_valid, key, state);
        end
    endtask

`ifdef AES_LOADER_FRAME_CHECK_EN
    task automatic test_frame_check();
        logic [15:0][7:0] es;
        for (int i = 0; i < 16; i++) es[i] = 8'(8'h90 + i);
        do_reset();
        blk_ready = 1'b1;
        for (int i = 0; i < 16; i++) send(8'(i), 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) send(8'(8'h70 + i), 1'b0, i == 9);
        checks++;
        if (frame_err !== 1'b1 || blk_valid !== 1'b0) begin
            errors++;
            $display("FAIL frm_err ferr %b vld %b want 1 0", frame_err, blk_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (frame_err !== 1'b0) begin
            errors++; $display("FAIL frm_pulse got %b want 0", frame_err);
        end
        for (int i = 0; i < 16; i++) send(8'(8'h90 + i), 1'b0, i == 15);
        checks++;
        if (blk_valid !== 1'b1 || state !== es) begin
            errors++;
            $display("FAIL frm_good vld %b state %h", blk_valid, state);
        end
    endtask
`else
    task automatic test_last_ignored();
        logic [15:0][7:0] es;
        for (int i = 0; i < 16; i++) es[i] = 8'(8'ha0 + i);
        do_reset();
        blk_ready = 1'b1;
        for (int i = 0; i < 16; i++) send(8'(i), 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) send(8'(8'ha0 + i), 1'b0, i == 3);
        checks++;
        if (frame_err !== 1'b0) begin
            errors++; $display("FAIL last_ferr got %b want 0", frame_err);
        end
        for (int i = 4; i < 16; i++) send(8'(8'ha0 + i), 1'b0, 1'b0);
        checks++;
        if (blk_valid !== 1'b1 || state !== es) begin
            errors++;
            $display("FAIL last_blk vld %b state %h", blk_valid, state);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_key_reuse();
        test_data_before_key();
        test_reset_mid();
`ifdef AES_LOADER_FRAME_CHECK_EN
        test_frame_check();
`else
        test_last_ignored();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
